nearest_center_select: RTL and testbench

//  Downstream consumer of the per-center squared-distance stage. Receives one scaled

---
 rtl/kd_pkg.sv | 25 ++
 rtl/nc_cross_mul.sv | 55 +++++
 rtl/nearest_center_select.sv | 136 +++++++++++++
 tb/tb_nearest_center_select.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/kd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kd_pkg
// Purpose  : Shared widths and FSM state encoding for the nearest-center
//            selection block of the kd-tree clustering pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package kd_pkg;

  localparam int DIST_W = 40;             // scaled total squared distance
  localparam int N_W    = 7;              // center point count (max_n = 100)
  localparam int ID_W   = 4;              // center identifier
  localparam int N2_W   = 2 * N_W;        // n^2
  localparam int PROD_W = DIST_W + N2_W;  // dist * n^2, never truncated

  typedef enum logic [2:0] {
    ST_ACCEPT = 3'd0,
    ST_SQR    = 3'd1,
    ST_MUL    = 3'd2,
    ST_CMP    = 3'd3,
    ST_EMIT   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nc_cross_mul.sv
`default_nettype none
// ============================================================================
// Module   : nc_cross_mul
// Purpose  : Two registered stages that square the point counts and then form
//            the cross products pc = cand_dist*best_n^2, pb = best_dist*cand_n^2,
//            so candidates can be ranked without dividing by n^2.
// Revision : 1.0 - initial release
// ============================================================================
module nc_cross_mul
  import kd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sqr_en,
  input  logic              mul_en,
  input  logic [DIST_W-1:0] cand_dist,
  input  logic [N_W-1:0]    cand_n,
  input  logic [DIST_W-1:0] best_dist,
  input  logic [N_W-1:0]    best_n,
  output logic [PROD_W-1:0] pc,
  output logic [PROD_W-1:0] pb
);

  logic [N2_W-1:0]   r_cn2;
  logic [N2_W-1:0]   r_bn2;
  logic [PROD_W-1:0] r_pc;
  logic [PROD_W-1:0] r_pb;

  // Squaring stage: both counts squared at full 2*N_W width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cn2 <= '0;
      r_bn2 <= '0;
    end else if (sqr_en) begin
      r_cn2 <= N2_W'(cand_n) * N2_W'(cand_n);
      r_bn2 <= N2_W'(best_n) * N2_W'(best_n);
    end
  end

  // Cross-product stage: operands widened first so nothing wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_pb <= '0;
    end else if (mul_en) begin
      r_pc <= PROD_W'(cand_dist) * PROD_W'(r_bn2);
      r_pb <= PROD_W'(best_dist) * PROD_W'(r_cn2);
    end
  end

  assign pc = r_pc;
  assign pb = r_pb;

endmodule
`default_nettype wire

// File: rtl/nearest_center_select.sv
`default_nettype none
// ============================================================================
// Module   : nearest_center_select
// Purpose  : Sequentially ranks candidate centers for one point by
//            cross-multiplied scaled distance and emits the nearest one.
//            One candidate per 4 cycles; result 3 cycles after the last one.
// Revision : 1.0 - initial release
// ============================================================================
module nearest_center_select
  import kd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cand_valid,
  output logic              cand_ready,
  input  logic [DIST_W-1:0] cand_dist,
  input  logic [N_W-1:0]    cand_n,
  input  logic [ID_W-1:0]   cand_id,
  input  logic              cand_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ID_W-1:0]   res_id,
  output logic [DIST_W-1:0] res_dist,
  output logic [N_W-1:0]    res_n,
  output logic              res_none
);

  state_t r_state;
  state_t w_next;

  logic [DIST_W-1:0] r_cand_dist;
  logic [N_W-1:0]    r_cand_n;
  logic [ID_W-1:0]   r_cand_id;
  logic              r_cand_last;

  logic [DIST_W-1:0] r_best_dist;
  logic [N_W-1:0]    r_best_n;
  logic [ID_W-1:0]   r_best_id;
  logic              r_have_best;

  logic [PROD_W-1:0] w_pc;
  logic [PROD_W-1:0] w_pb;
  logic              w_take;
  logic              w_cand_hs;
  logic              w_res_hs;

  assign w_cand_hs = (r_state == ST_ACCEPT) && cand_valid;
  assign w_res_hs  = (r_state == ST_EMIT) && res_ready;
  // Zero-count centers are empty and never win; strict < keeps the earlier on ties
  assign w_take    = (r_cand_n != '0) && (!r_have_best || (w_pc < w_pb));

  nc_cross_mul u_cross_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .sqr_en    (r_state == ST_SQR),
    .mul_en    (r_state == ST_MUL),
    .cand_dist (r_cand_dist),
    .cand_n    (r_cand_n),
    .best_dist (r_best_dist),
    .best_n    (r_best_n),
    .pc        (w_pc),
    .pb        (w_pb)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACCEPT;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_ACCEPT: if (cand_valid) w_next = ST_SQR;
      ST_SQR:    w_next = ST_MUL;
      ST_MUL:    w_next = ST_CMP;
      ST_CMP:    w_next = r_cand_last ? ST_EMIT : ST_ACCEPT;
      ST_EMIT:   if (res_ready) w_next = ST_ACCEPT;
      default:   w_next = ST_ACCEPT;
    endcase
  end

  // Output decode: result fields are only presented while emitting
  always_comb begin
    cand_ready = (r_state == ST_ACCEPT);
    res_valid  = (r_state == ST_EMIT);
    res_id     = '0;
    res_dist   = '0;
    res_n      = '0;
    res_none   = 1'b0;
    if (r_state == ST_EMIT) begin
      res_id   = r_best_id;
      res_dist = r_best_dist;
      res_n    = r_best_n;
      res_none = !r_have_best;
    end
  end

  // Candidate capture on the input handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand_dist <= '0;
      r_cand_n    <= '0;
      r_cand_id   <= '0;
      r_cand_last <= 1'b0;
    end else if (w_cand_hs) begin
      r_cand_dist <= cand_dist;
      r_cand_n    <= cand_n;
      r_cand_id   <= cand_id;
      r_cand_last <= cand_last;
    end
  end

  // Running best: updated in CMP, cleared once the result is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_dist <= '0;
      r_best_n    <= '0;
      r_best_id   <= '0;
      r_have_best <= 1'b0;
    end else if (w_res_hs) begin
      r_best_dist <= '0;
      r_best_n    <= '0;
      r_best_id   <= '0;
      r_have_best <= 1'b0;
    end else if ((r_state == ST_CMP) && w_take) begin
      r_best_dist <= r_cand_dist;
      r_best_n    <= r_cand_n;
      r_best_id   <= r_cand_id;
      r_have_best <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nearest_center_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_nearest_center_select
// Purpose  : Directed self-checking bench for nearest_center_select.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nearest_center_select;
  import kd_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              cand_valid;
  logic              cand_ready;
  logic [DIST_W-1:0] cand_dist;
  logic [N_W-1:0]    cand_n;
  logic [ID_W-1:0]   cand_id;
  logic              cand_last;
  logic              res_valid;
  logic              res_ready;
  logic [ID_W-1:0]   res_id;
  logic [DIST_W-1:0] res_dist;
  logic [N_W-1:0]    res_n;
  logic              res_none;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [DIST_W-1:0] DMAX = {DIST_W{1'b1}};

  nearest_center_select dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_dist  (cand_dist),
    .cand_n     (cand_n),
    .cand_id    (cand_id),
    .cand_last  (cand_last),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_dist   (res_dist),
    .res_n      (res_n),
    .res_none   (res_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one candidate; returns one step after its handshake edge.
  // With noisy=1 junk candidates are waved at the block while it is busy.
  task automatic send_cand(input logic [DIST_W-1:0] d, input logic [N_W-1:0] n,
                           input logic [ID_W-1:0] id, input logic last, input bit noisy);
    int guard = 0;
    while (!cand_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("cand_ready_wait", cand_ready, 1);
    cand_valid = 1'b1;
    cand_dist  = d;
    cand_n     = n;
    cand_id    = id;
    cand_last  = last;
    tick();
    cand_valid = 1'b0;
    if (noisy) begin
      for (int k = 0; k < 3; k++) begin
        cand_valid = k[0] ? 1'b0 : 1'b1;
        cand_dist  = '0;
        cand_n     = 7'd1;
        cand_id    = 4'd15;
        cand_last  = 1'b1;
        check("busy_ready_low", cand_ready, 0);
        tick();
      end
      cand_valid = 1'b0;
    end
  endtask

  // Wait for the result, check latency and fields, optionally stall, then accept.
  task automatic get_result(input string tag, input logic [ID_W-1:0] eid,
                            input logic [DIST_W-1:0] ed, input logic [N_W-1:0] en,
                            input logic enone, input int hold);
    int lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_id"}, res_id, eid);
    check({tag, "_dist"}, res_dist, ed);
    check({tag, "_n"}, res_n, en);
    check({tag, "_none"}, res_none, enone);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_valid"}, res_valid, 1);
      check({tag, "_hold_id"}, res_id, eid);
      check({tag, "_hold_dist"}, res_dist, ed);
      check({tag, "_hold_ready"}, cand_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_back_to_accept"}, cand_ready, 1);
    check({tag, "_valid_dropped"}, res_valid, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    cand_valid = 1'b0;
    cand_dist  = '0;
    cand_n     = '0;
    cand_id    = '0;
    cand_last  = 1'b0;
    res_ready  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_cand_ready", cand_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_dist", res_dist, 0);
    check("rst_res_n", res_n, 0);
    check("rst_res_none", res_none, 0);

    // Reset mid-stream: a strong first candidate must not survive reset
    send_cand(40'd1, 7'd1, 4'd4, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_async_ready", cand_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_valid", res_valid, 0);
    check("midrst_ready", cand_ready, 1);
    repeat (6) tick();
    check("midrst_no_result", res_valid, 0);
    // 40*2^2=160 < 50*3^2=450 -> second wins
    send_cand(40'd50, 7'd2, 4'd6, 1'b0, 1'b0);
    send_cand(40'd40, 7'd3, 4'd8, 1'b1, 1'b0);
    get_result("midrst_point", 4'd8, 40'd40, 7'd3, 1'b0, 0);

    // Ordering: 30*4=120 vs 100*1=100 -> first kept
    send_cand(40'd100, 7'd2, 4'd0, 1'b0, 1'b0);
    send_cand(40'd30, 7'd1, 4'd1, 1'b1, 1'b0);
    get_result("order", 4'd0, 40'd100, 7'd2, 1'b0, 0);

    // Tie: 16*1 vs 4*4 -> earlier kept
    send_cand(40'd4, 7'd1, 4'd3, 1'b0, 1'b0);
    send_cand(40'd16, 7'd2, 4'd5, 1'b1, 1'b0);
    get_result("tie", 4'd3, 40'd4, 7'd1, 1'b0, 0);

    // Empty center skipped
    send_cand(40'd50, 7'd0, 4'd2, 1'b0, 1'b0);
    send_cand(40'd9, 7'd3, 4'd7, 1'b1, 1'b0);
    get_result("empty_skip", 4'd7, 40'd9, 7'd3, 1'b0, 0);

    // All empty
    send_cand(40'd5, 7'd0, 4'd1, 1'b0, 1'b0);
    send_cand(40'd6, 7'd0, 4'd4, 1'b1, 1'b0);
    get_result("all_empty", 4'd0, 40'd0, 7'd0, 1'b1, 0);

    // Single candidate; then backpressure for 10 cycles
    send_cand(40'd20, 7'd2, 4'd9, 1'b1, 1'b0);
    get_result("backpressure", 4'd9, 40'd20, 7'd2, 1'b0, 10);
    send_cand(40'd7, 7'd1, 4'd2, 1'b1, 1'b0);
    get_result("after_bp", 4'd2, 40'd7, 7'd1, 1'b0, 0);

    // Extremes: max distance, n=127 vs n=1, with bus noise while busy
    send_cand(DMAX, 7'd127, 4'd10, 1'b0, 1'b1);
    send_cand(DMAX, 7'd1, 4'd11, 1'b1, 1'b0);
    get_result("extreme_a", 4'd10, DMAX, 7'd127, 1'b0, 0);
    send_cand(DMAX, 7'd1, 4'd12, 1'b0, 1'b1);
    send_cand(DMAX, 7'd127, 4'd13, 1'b1, 1'b0);
    get_result("extreme_b", 4'd13, DMAX, 7'd127, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
